unit_lit_encoder: RTL
=====================

Name: unit_lit_encoder

Overview:
- Converts the per-variable unit-assignment vectors (mark flag plus boolean value per variable index) back into a stream of signed literals.
- Literal format is the clause-literal format used across the DPLL datapath: WIDTH-bit two's complement, +v for a true assignment, -v for a false one.
- Sits after the unit-clause marking stage and feeds the implication/trail writer, one literal per valid/ready handshake.

Parameters:
- WIDTH, 9, literal width; MSB is the sign bit; magnitude lives in WIDTH-1 bits.
- MAX_SIZE, 256, number of variable slots (index 0 reserved). Must satisfy MAX_SIZE <= 2^(WIDTH-1).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  Pulse: capture both vectors and begin encoding. Sampled only in IDLE.
- mark_packed  in  MAX_SIZE  Bit v=1 means variable v carries a unit assignment.
- bool_packed  in  MAX_SIZE  Bit v is the value of variable v; meaningful only where mark bit v=1.
- flush  in  1  Synchronous abort back to IDLE.
- lit_out  out  WIDTH  Current literal.
- lit_valid  out  1  lit_out holds a valid literal.
- lit_ready  in  1  Consumer accepts lit_out.
- busy  out  1  High in SCAN, EMIT and DONE.
- done  out  1  One-cycle pulse after the last literal is accepted, or after a scan finds none.
- lit_count  out  WIDTH  Number of literals accepted since the last start.

Behaviour:
- States: IDLE, SCAN, EMIT, DONE.
- Reset values: state=IDLE, lit_out=0, lit_valid=0, busy=0, done=0, lit_count=0, pending=0, val_reg=0.
- IDLE, start=1:
  - pending <= mark_packed with bit 0 forced to 0 (index 0 is never emitted).
  - val_reg <= bool_packed.
  - lit_count <= 0.
  - Go to SCAN.
- Start is ignored in every other state; the captured vectors are not affected by later input changes.
- SCAN (exactly 1 cycle):
  - Priority-encode the lowest set bit p of pending.
  - If pending==0: go to DONE.
  - Else: lit_out <= val_reg[p] ? p : (2^WIDTH - p) mod 2^WIDTH; lit_valid <= 1; clear pending[p]; go to EMIT.
- EMIT: lit_out and lit_valid are held stable until lit_valid && lit_ready. On that edge:
  - lit_count increments.
  - If pending!=0: load the next lowest literal in the same edge, lit_valid stays 1, clear that bit. This gives one literal per cycle while lit_ready is held high.
  - If pending==0: lit_valid <= 0; go to DONE.
- DONE (1 cycle): done=1, busy=1; next state IDLE, where busy=0.
- Latency:
  - start high at edge N: first literal valid in cycle N+2; an empty scan pulses done in cycle N+2.
  - Last accept at edge M: done high in cycle M+1.
- Order: ascending variable index, strictly.
- lit_count: counts up to MAX_SIZE-1 and cannot overflow; it holds its value after done until the next start.
- flush (any state, priority over all else):
  - Next cycle: IDLE, lit_valid=0, pending=0, done=0.
  - lit_count holds its value.
- lit_ready while lit_valid=0 has no effect.
- Asynchronous reset mid-operation: every output returns to its reset value immediately; no literal is emitted after reset release without a new start.
- Magnitude uses bits [WIDTH-2:0] of the index; the negative encoding is the two's complement of the zero-extended index.

Test Plan:
- mark bits {3,5}, bool 3=1 / 5=0, lit_ready=1 → lit_out 9'h003 then 9'h1FB on consecutive cycles; done one cycle after the second accept; lit_count=2.
- mark=0 (or only bit 0 set), start → no lit_valid; done in cycle N+2; lit_count=0.
- mark bits {1,255}, both false, lit_ready low for 4 cycles then high → 9'h1FF held stable for 4 cycles, then 9'h101; done once.
- All bits 1..255 marked, bool alternating, lit_ready=1 → 255 literals in 255 consecutive cycles, ascending order; lit_count=255 (9'h0FF).
- start pulsed again during EMIT → ignored, sequence unchanged; flush while the 2nd of 4 literals is pending → lit_valid low next cycle, IDLE, no done.
- rst_n low in mid-stream → lit_valid, busy and lit_count are 0 asynchronously; after release with no start, nothing is emitted.

Source files
------------

// File: rtl/unit_lit_encoder.sv
// rtl/unit_lit_encoder.sv - turns unit-assignment mark/value vectors into an ascending stream of signed literals
module unit_lit_encoder #(
    parameter int WIDTH    = 9,
    parameter int MAX_SIZE = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MAX_SIZE-1:0] mark_packed,
    input  logic [MAX_SIZE-1:0] bool_packed,
    input  logic                flush,
    output logic [WIDTH-1:0]    lit_out,
    output logic                lit_valid,
    input  logic                lit_ready,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    lit_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MAX_SIZE-1:0] pending;
    logic [MAX_SIZE-1:0] val_reg;

    logic [WIDTH-2:0]    low_idx;
    logic                low_val;
    logic                pending_any;
    logic [MAX_SIZE-1:0] pending_rest;
    logic [WIDTH-1:0]    lit_enc;
    logic                accept;

    // Lowest pending variable and its captured value; descending loop so the smallest index wins
    always_comb begin
        low_idx = '0;
        low_val = 1'b0;
        for (int i = MAX_SIZE - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = i[WIDTH-2:0];
                low_val = val_reg[i];
            end
        end
    end

    // Signed literal for the lowest pending variable; clearing the lowest set bit via x & (x-1)
    always_comb begin
        pending_any  = |pending;
        pending_rest = pending & (pending - MAX_SIZE'(1));
        lit_enc      = low_val ? {1'b0, low_idx} : (WIDTH'(0) - {1'b0, low_idx});
        accept       = lit_valid && lit_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_SCAN;
            S_SCAN: state_nxt = pending_any ? S_EMIT : S_DONE;
            S_EMIT: if (accept && !pending_any) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: vector capture, literal load on scan/accept, accepted-literal counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            val_reg   <= '0;
            lit_out   <= '0;
            lit_valid <= 1'b0;
            lit_count <= '0;
        end else if (flush) begin
            pending   <= '0;
            lit_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending   <= mark_packed & ~MAX_SIZE'(1);
                        val_reg   <= bool_packed;
                        lit_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (pending_any) begin
                        lit_out   <= lit_enc;
                        lit_valid <= 1'b1;
                        pending   <= pending_rest;
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        lit_count <= lit_count + WIDTH'(1);
                        if (pending_any) begin
                            lit_out <= lit_enc;
                            pending <= pending_rest;
                        end else begin
                            lit_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
